// File: rtl/me_pkg.sv
// Shared constants and types for the SAD motion-estimation block.
// MACRO_DIM_DEFAULT : default macroblock edge in pixels
// PIXEL_W           : pixel width
// COL_SAD_W         : width of one column's absolute-difference sum
// SAD_W             : width of the full-block SAD
package me_pkg;

  localparam int unsigned MACRO_DIM_DEFAULT = 16;
  localparam int unsigned PIXEL_W           = 8;
  localparam int unsigned COL_SAD_W         = 12;
  localparam int unsigned SAD_W             = 16;

  typedef logic [PIXEL_W-1:0] pixel_t;
  // One pixel column at the default macroblock size; element j is row j.
  typedef pixel_t [MACRO_DIM_DEFAULT-1:0] pixel_col_t;

endpackage

// File: rtl/me_col_sad.sv
// Combinational sum of absolute differences for one column pair.
// Ports:
//   cur_col : current-picture column, element j = row j
//   ref_col : reference (search) column, element j = row j
//   col_sad : sum over rows of |cur - ref|
module me_col_sad
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM = MACRO_DIM_DEFAULT
) (
  input  logic [MACRO_DIM-1:0][PIXEL_W-1:0] cur_col,
  input  logic [MACRO_DIM-1:0][PIXEL_W-1:0] ref_col,
  output logic [COL_SAD_W-1:0]              col_sad
);

  logic signed [PIXEL_W:0]  diff [MACRO_DIM];
  logic        [PIXEL_W-1:0] mag [MACRO_DIM];

  for (genvar r = 0; r < MACRO_DIM; r++) begin : g_row
    assign diff[r] = $signed({1'b0, cur_col[r]}) - $signed({1'b0, ref_col[r]});
    // |diff| never exceeds 255, so the negated value fits back into a pixel width.
    assign mag[r]  = diff[r][PIXEL_W] ? PIXEL_W'(-diff[r]) : diff[r][PIXEL_W-1:0];
  end

  always_comb begin
    col_sad = '0;
    for (int unsigned r = 0; r < MACRO_DIM; r++) begin
      col_sad = col_sad + COL_SAD_W'(mag[r]);
    end
  end

endmodule

// File: rtl/me.sv
// Macroblock SAD engine: two column-shift registers (current picture CPR and
// search picture SPR) and a registered sum of absolute differences.
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous active-high reset, clears both arrays and sad
//   en_spr       : shift SPR one column and load pixel_spr_in at the top column
//   en_cpr       : shift CPR one column and load pixel_cpr_in at the top column
//   pixel_spr_in : incoming reference column, element j = row j
//   pixel_cpr_in : incoming current column, element j = row j
//   sad          : SAD of the array contents as they stood before the last edge
module me
  import me_pkg::*;
#(
  parameter int unsigned MACRO_DIM = MACRO_DIM_DEFAULT
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              en_spr,
  input  logic                              en_cpr,
  input  logic [MACRO_DIM-1:0][PIXEL_W-1:0] pixel_spr_in,
  input  logic [MACRO_DIM-1:0][PIXEL_W-1:0] pixel_cpr_in,
  output logic [SAD_W-1:0]                  sad
);

  typedef logic [MACRO_DIM-1:0][PIXEL_W-1:0] col_t;

  col_t cpr_q [MACRO_DIM];
  col_t cpr_d [MACRO_DIM];
  col_t spr_q [MACRO_DIM];
  col_t spr_d [MACRO_DIM];

  logic [COL_SAD_W-1:0] col_sad [MACRO_DIM];
  logic [SAD_W-1:0]     sad_d;
  logic [SAD_W-1:0]     sad_q;

  // Column c takes column c+1; the newest column enters at the top index.
  always_comb begin
    cpr_d = cpr_q;
    spr_d = spr_q;
    if (en_cpr) begin
      for (int unsigned c = 0; c < MACRO_DIM - 1; c++) begin
        cpr_d[c] = cpr_q[c+1];
      end
      cpr_d[MACRO_DIM-1] = pixel_cpr_in;
    end
    if (en_spr) begin
      for (int unsigned c = 0; c < MACRO_DIM - 1; c++) begin
        spr_d[c] = spr_q[c+1];
      end
      spr_d[MACRO_DIM-1] = pixel_spr_in;
    end
  end

  for (genvar c = 0; c < MACRO_DIM; c++) begin : g_col
    me_col_sad #(
      .MACRO_DIM(MACRO_DIM)
    ) u_col_sad (
      .cur_col(cpr_q[c]),
      .ref_col(spr_q[c]),
      .col_sad(col_sad[c])
    );
  end

  // Column sums combine into the block total; 256 x 255 fits 16 bits.
  always_comb begin
    sad_d = '0;
    for (int unsigned c = 0; c < MACRO_DIM; c++) begin
      sad_d = sad_d + SAD_W'(col_sad[c]);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned c = 0; c < MACRO_DIM; c++) begin
        cpr_q[c] <= '0;
        spr_q[c] <= '0;
      end
      sad_q <= '0;
    end else begin
      cpr_q <= cpr_d;
      spr_q <= spr_d;
      sad_q <= sad_d;
    end
  end

  assign sad = sad_q;

endmodule

// File: tb/tb_me.sv
module tb_me;
  import me_pkg::*;

  logic       clk;
  logic       rst;
  logic       en_spr;
  logic       en_cpr;
  pixel_col_t pixel_spr_in;
  pixel_col_t pixel_cpr_in;
  logic [15:0] sad;

  int checks;
  int failures;

  me #(
    .MACRO_DIM(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en_spr(en_spr),
    .en_cpr(en_cpr),
    .pixel_spr_in(pixel_spr_in),
    .pixel_cpr_in(pixel_cpr_in),
    .sad(sad)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs, take the edge, settle 1 time unit past it.
  task automatic step(input pixel_col_t c, input pixel_col_t s, input logic ec, input logic es);
    pixel_cpr_in = c;
    pixel_spr_in = s;
    en_cpr       = ec;
    en_spr       = es;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step('0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    pixel_col_t c;
    pixel_col_t s;
    checks       = 0;
    failures     = 0;
    rst          = 1'b0;
    en_spr       = 1'b0;
    en_cpr       = 1'b0;
    pixel_spr_in = '0;
    pixel_cpr_in = '0;

    // Asynchronous clear before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("reset_async", sad, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    check("reset_idle", sad, 16'd0);

    // Identical data in both arrays.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) c[j] = 8'(k * 16 + j);
      step(c, c, 1'b1, 1'b1);
    end
    idle();
    check("identical", sad, 16'd0);

    // CPR all 0xFF vs SPR all 0x00; after the 16th edge only 15 columns differ.
    for (int k = 0; k < 16; k++) step({16{8'hFF}}, '0, 1'b1, 1'b1);
    check("ff_latency", sad, 16'd61200);
    idle();
    check("ff_full", sad, 16'd65280);

    // Single pixel difference at row 3, column 7.
    for (int k = 0; k < 16; k++) begin
      c = {16{8'h40}};
      s = {16{8'h40}};
      if (k == 7) begin
        c[3] = 8'h0A;
        s[3] = 8'h05;
      end
      step(c, s, 1'b1, 1'b1);
    end
    idle();
    check("one_pixel", sad, 16'd5);
    for (int k = 0; k < 16; k++) begin
      c = {16{8'h40}};
      s = {16{8'h40}};
      if (k == 7) begin
        c[3] = 8'h05;
        s[3] = 8'h0A;
      end
      step(c, s, 1'b1, 1'b1);
    end
    idle();
    check("one_pixel_swap", sad, 16'd5);

    // CPR 200 everywhere, SPR column k row j = 4k+j: column sum 3080-64k, total 41600.
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) s[j] = 8'(4 * k + j);
      step({16{8'd200}}, s, 1'b1, 1'b1);
    end
    step({16{8'h33}}, {16{8'h33}}, 1'b1, 1'b1);
    check("slide_before", sad, 16'd41600);
    idle();
    check("slide_after", sad, 16'd38520);
    for (int n = 0; n < 4; n++) begin
      idle();
      check("hold", sad, 16'd38520);
    end

    // CPR only: SPR stays cleared and must ignore its input.
    do_reset();
    for (int k = 0; k < 16; k++) step({16{8'h01}}, {16{8'hAA}}, 1'b1, 1'b0);
    check("cpr_only_latency", sad, 16'd240);
    idle();
    check("cpr_only", sad, 16'd256);

    // SPR only: fill SPR with 0x02 against the 0x01 CPR.
    for (int k = 0; k < 16; k++) step({16{8'hEE}}, {16{8'h02}}, 1'b0, 1'b1);
    idle();
    check("spr_only", sad, 16'd256);

    // Reset mid-load.
    do_reset();
    for (int k = 0; k < 8; k++) step({16{8'h10}}, '0, 1'b1, 1'b1);
    check("partial_load", sad, 16'd1792);
    #2 rst = 1'b1;
    #1;
    check("midload_reset_async", sad, 16'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    check("regs_cleared", sad, 16'd0);
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) c[j] = 8'(255 - k * 3 - j);
      step(c, c, 1'b1, 1'b1);
    end
    idle();
    check("reload_identical", sad, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/me.md
ME -- requirements
Module: me

Interface
REQ-001 Parameter MACRO_DIM, default 16, macroblock edge in pixels (rows per column, columns per block).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 en_spr  input  1  shift-enable for the search-picture register (SPR).
REQ-005 en_cpr  input  1  shift-enable for the current-picture register (CPR).
REQ-006 pixel_spr_in  input  MACRO_DIM x 8  one reference column; element j = row j, unsigned 8-bit.
REQ-007 pixel_cpr_in  input  MACRO_DIM x 8  one current-picture column; element j = row j, unsigned 8-bit.
REQ-008 sad  output  16  registered sum of absolute differences between CPR and SPR contents.

Function
REQ-009 CPR SHALL be a MACRO_DIM x MACRO_DIM array of 8-bit pixels organised as MACRO_DIM columns.
REQ-010 On a clock edge with en_cpr=1, CPR columns SHALL shift one place (column c takes column c+1, column 0 discarded) and column MACRO_DIM-1 SHALL load pixel_cpr_in.
REQ-011 With en_cpr=0, CPR SHALL hold.
REQ-012 SPR SHALL be an identical, independent MACRO_DIM x MACRO_DIM array controlled by en_spr and pixel_spr_in with the same shift rule.
REQ-013 en_cpr and en_spr SHALL act independently; both high in one cycle shifts both registers.
REQ-014 After MACRO_DIM consecutive enabled cycles, CPR column c SHALL hold the column presented on cycle c (0-based); further shifts slide the window by one column per cycle.
REQ-015 Combinational SAD SHALL be sum over all (row, col) of |CPR[r][c] - SPR[r][c]|, differences computed as 9-bit signed, magnitudes 8-bit unsigned.
REQ-016 Per-column sums SHALL be 12 bits; total SHALL be 16 bits; maximum 256 x 255 = 65280, no overflow, no saturation needed.
REQ-017 sad SHALL be registered every clock edge from the combinational SAD of the register contents before that edge; hence sad reflects a column load one cycle after it (latency 1 cycle from shift to sad update).
REQ-018 sad SHALL update every cycle regardless of enables; with both enables low it stays constant after one cycle.
REQ-019 No handshake or valid output; the user counts MACRO_DIM loads plus one cycle before sampling sad.

Reset
REQ-020 While rst=1, all CPR and SPR pixels and sad SHALL be 0, asynchronously.
REQ-021 Reset asserted mid-load SHALL discard partial columns; loading restarts from column 0 count after release.
REQ-022 First shift SHALL occur on the first rising edge with rst=0 and an enable high.

Structure
REQ-023 Package me_pkg SHALL hold MACRO_DIM default, PIXEL_W=8, COL_SAD_W=12, SAD_W=16 and a pixel-column typedef.
REQ-024 One sub-module me_col_sad SHALL compute the absolute-difference sum of one column pair (MACRO_DIM pixels each); me instantiates MACRO_DIM copies and an adder tree.
REQ-025 Only the CPR, SPR and sad register are sequential; no other state.

Verification
REQ-026 Identical CPR/SPR data, 16 columns loaded -> sad = 0 one cycle after last load.
REQ-027 CPR all 0xFF, SPR all 0x00, 16 columns -> sad = 65280 (0xFF00).
REQ-028 All pixels equal except CPR row 3 col 7 = 0x0A vs SPR 0x05 -> sad = 5; swapped values -> also 5.
REQ-029 Load 16 differing columns then a 17th identical pair with en high -> sad drops by column 0's contribution one cycle later; en low for 4 cycles -> sad unchanged.
REQ-030 en_cpr=1, en_spr=0 for 16 cycles with CPR all 0x01 after reset -> sad = 256.
REQ-031 Assert rst after 8 loaded columns -> sad = 0 immediately and registers cleared; reload 16 identical columns -> sad = 0.
